// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
// Width helper, length clamp and the shadow configuration bundle.
package seq_det_pkg;

   localparam int CFG_PAT_MAX = 64;
   localparam int CFG_LEN_MAX = 7;

   typedef struct packed {
      logic [CFG_PAT_MAX-1:0] pat;
      logic [CFG_LEN_MAX-1:0] len;
      logic                   ovl;
   } seq_det_cfg_t;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Lengths beyond the history depth behave as the full depth.
   function automatic logic [CFG_LEN_MAX-1:0] eff_len(
      input logic [CFG_LEN_MAX-1:0] len,
      input int                     max_len
   );
      logic [CFG_LEN_MAX-1:0] lim;
      lim = CFG_LEN_MAX'(max_len);
      return (len > lim) ? lim : len;
   endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational pattern comparator for seq_det_param.
// Compares the low len bits of the next history against the pattern.
module seq_det_match
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = len_w(MAX_LEN)
) (
   input  logic [MAX_LEN-1:0] hist_n,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LW-1:0]      len,
   input  logic [LW-1:0]      fill_n,
   output logic               hit
);

   logic [MAX_LEN-1:0] mask;

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (LW'(i) < len);
      end
   end

   assign hit = (len != '0) &&
                (fill_n >= len) &&
                (((hist_n ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial sequence detector with registered detect.
// Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1001,
   parameter int                 RST_LEN     = 4,
   parameter bit                 RST_OVERLAP = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           din,
   input  logic                           din_valid,
   input  logic                           cfg_load,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
   input  logic                           count_clr,
   output logic                           detect,
   output logic [CNT_W-1:0]               match_count
);

   localparam int LW = len_w(MAX_LEN);

   seq_det_cfg_t       cfg_q;
   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_n;
   logic [LW-1:0]      fill;
   logic [LW-1:0]      fill_n;
   logic [LW-1:0]      len_e;
   logic               hit;
   logic               accept;
   logic               cfg_unused;

   assign accept = din_valid & ~cfg_load;
   assign hist_n = {hist[MAX_LEN-2:0], din};
   assign fill_n = (fill >= LW'(MAX_LEN)) ? fill : fill + LW'(1);
   assign len_e  = LW'(eff_len(cfg_q.len, MAX_LEN));

   // Upper struct bits exist only to fit the widest supported pattern.
   assign cfg_unused = ^cfg_q;

   seq_det_match #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_match (
      .hist_n (hist_n),
      .pat    (cfg_q.pat[MAX_LEN-1:0]),
      .len    (len_e),
      .fill_n (fill_n),
      .hit    (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q.pat <= CFG_PAT_MAX'(RST_PATTERN);
         cfg_q.len <= CFG_LEN_MAX'(RST_LEN);
         cfg_q.ovl <= RST_OVERLAP;
         hist      <= '0;
         fill      <= '0;
         detect    <= 1'b0;
      end else if (cfg_load) begin
         cfg_q.pat <= CFG_PAT_MAX'(cfg_pattern);
         cfg_q.len <= CFG_LEN_MAX'(cfg_len);
         cfg_q.ovl <= cfg_overlap;
         hist      <= '0;
         fill      <= '0;
         detect    <= 1'b0;
      end else if (din_valid) begin
         hist   <= hist_n;
         detect <= hit;
         // Non-overlap mode needs a fresh full pattern after a match.
         fill   <= (hit && !cfg_q.ovl) ? '0 : fill_n;
      end
   end

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || count_clr) begin
         cnt_q <= '0;
      end else if (accept && hit && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign match_count = cnt_q;
`else
   logic count_unused;

   assign count_unused = count_clr ^ accept;
   assign match_count  = '0;
`endif

endmodule
